// File: rtl/debug_defs.sv
// Shared command opcodes, word width and FSM state encoding for the debug loader.
package debug_defs;

  localparam int WORD_W = 16;

  localparam logic [7:0] CMD_LOAD_PM  = 8'h01;
  localparam logic [7:0] CMD_RUN      = 8'h02;
  localparam logic [7:0] CMD_DUMP     = 8'h03;
  localparam logic [7:0] CMD_WRITE_DM = 8'h04;

  typedef enum logic [4:0] {
    IDLE,
    LD_CNT_H, LD_CNT_L, LD_HI, LD_LO, LD_WR,
    WD_AH, WD_AL, WD_DH, WD_DL, WD_WR,
    RUN_H, RUN_L, RUNNING,
    DUMP_RD, DUMP_CAP,
    TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT
  } state_e;

endpackage

// File: rtl/word_assembler.sv
// Collects two bytes (high first) into a 16-bit word; word_vld pulses with the low byte.
module word_assembler
  import debug_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_vld,
  input  logic [7:0]        byte_in,
  output logic              word_vld,
  output logic [WORD_W-1:0] word
);

  logic       have_hi_q, have_hi_d;
  logic [7:0] hi_q, hi_d;

  always_comb begin
    have_hi_d = have_hi_q;
    hi_d      = hi_q;
    if (clear) begin
      have_hi_d = 1'b0;
    end else if (byte_vld) begin
      have_hi_d = ~have_hi_q;
      if (!have_hi_q) hi_d = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      have_hi_q <= 1'b0;
      hi_q      <= 8'h00;
    end else begin
      have_hi_q <= have_hi_d;
      hi_q      <= hi_d;
    end
  end

  assign word_vld = byte_vld & have_hi_q & ~clear;
  assign word     = {hi_q, byte_in};

endmodule

// File: rtl/debug_loader.sv
// Serial debug loader: loads program memory, writes data memory, runs the CPU
// for a bounded number of cycles and dumps ACC/PC/data memory over the UART.
module debug_loader
  import debug_defs::*;
#(
  parameter int DATA_LENGTH = 16,
  parameter int ADDR_LENGTH = 11,
  parameter int DUMP_WORDS  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  output logic                   reset_bip,
  output logic                   WrPM,
  output logic                   WrDM,
  output logic                   RdDM,
  output logic [DATA_LENGTH-1:0] dataFromInterface,
  output logic [ADDR_LENGTH-1:0] addrFromInterface,
  input  logic [DATA_LENGTH-1:0] outAcc,
  input  logic [DATA_LENGTH-1:0] outPC,
  input  logic [DATA_LENGTH-1:0] data_from_dm
);

  state_e                 state_q, state_d;
  logic [WORD_W-1:0]      cnt_q, cnt_d;
  logic [WORD_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]      tx_word_q, tx_word_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic [DATA_LENGTH-1:0] data_q, data_d;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic                   wr_pm_q, wr_pm_d;
  logic                   wr_dm_q, wr_dm_d;
  logic                   rd_dm_q, rd_dm_d;
  logic                   tx_start_q, tx_start_d;
  logic                   reset_bip_q, reset_bip_d;

  logic                   rx_field;
  logic                   word_vld;
  logic [WORD_W-1:0]      word;

  // Only field-receiving states feed the assembler; every other state drops rx bytes.
  assign rx_field = state_q inside {LD_CNT_H, LD_CNT_L, LD_HI, LD_LO,
                                    WD_AH, WD_AL, WD_DH, WD_DL, RUN_H, RUN_L};

  word_assembler u_word_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == IDLE),
    .byte_vld (rx_done & rx_field),
    .byte_in  (rx_data),
    .word_vld (word_vld),
    .word     (word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tx_word_d  = tx_word_q;
    tx_data_d  = tx_data_q;
    data_d     = data_q;
    addr_d     = addr_q;
    wr_pm_d    = 1'b0;
    wr_dm_d    = 1'b0;
    rd_dm_d    = 1'b0;
    tx_start_d = 1'b0;

    case (state_q)
      IDLE: if (rx_done) begin
        case (rx_data)
          CMD_LOAD_PM:  state_d = LD_CNT_H;
          CMD_RUN:      state_d = RUN_H;
          CMD_WRITE_DM: state_d = WD_AH;
          CMD_DUMP: begin
            idx_d     = '0;
            tx_word_d = WORD_W'(outAcc);
            state_d   = TX_HI;
          end
          default: ;
        endcase
      end

      LD_CNT_H: if (rx_done) state_d = LD_CNT_L;
      LD_CNT_L: if (word_vld) begin
        cnt_d   = word;
        idx_d   = '0;
        state_d = (word == '0) ? IDLE : LD_HI;
      end
      LD_HI: if (rx_done) state_d = LD_LO;
      LD_LO: if (word_vld) begin
        wr_pm_d = 1'b1;
        data_d  = DATA_LENGTH'(word);
        addr_d  = ADDR_LENGTH'(idx_q);
        state_d = LD_WR;
      end
      LD_WR: begin
        idx_d   = idx_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q <= 1) ? IDLE : LD_HI;
      end

      WD_AH: if (rx_done) state_d = WD_AL;
      WD_AL: if (word_vld) begin
        addr_d  = ADDR_LENGTH'(word);
        state_d = WD_DH;
      end
      WD_DH: if (rx_done) state_d = WD_DL;
      WD_DL: if (word_vld) begin
        wr_dm_d = 1'b1;
        data_d  = DATA_LENGTH'(word);
        state_d = WD_WR;
      end
      WD_WR: state_d = IDLE;

      RUN_H: if (rx_done) state_d = RUN_L;
      RUN_L: if (word_vld) begin
        cnt_d   = word;
        state_d = (word == '0) ? IDLE : RUNNING;
      end
      RUNNING: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = IDLE;
      end

      // RdDM is high during DUMP_RD; the memory answers one cycle later.
      DUMP_RD:  state_d = DUMP_CAP;
      DUMP_CAP: begin
        tx_word_d = WORD_W'(data_from_dm);
        state_d   = TX_HI;
      end

      TX_HI: if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = tx_word_q[15:8];
        state_d    = TX_HI_WAIT;
      end
      TX_HI_WAIT: if (tx_done) state_d = TX_LO;
      TX_LO: if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = tx_word_q[7:0];
        state_d    = TX_LO_WAIT;
      end
      TX_LO_WAIT: if (tx_done) begin
        idx_d = idx_q + 1'b1;
        if (idx_q + 16'd1 == WORD_W'(DUMP_WORDS + 2)) begin
          state_d = IDLE;
        end else if (idx_q == '0) begin
          tx_word_d = WORD_W'(outPC);
          state_d   = TX_HI;
        end else begin
          // Item idx_q+1 maps to data memory word idx_q+1-2.
          rd_dm_d = 1'b1;
          addr_d  = ADDR_LENGTH'(idx_q - 16'd1);
          state_d = DUMP_RD;
        end
      end

      default: state_d = IDLE;
    endcase

    reset_bip_d = (state_d != RUNNING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      tx_word_q   <= '0;
      tx_data_q   <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      wr_pm_q     <= 1'b0;
      wr_dm_q     <= 1'b0;
      rd_dm_q     <= 1'b0;
      tx_start_q  <= 1'b0;
      reset_bip_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_word_q   <= tx_word_d;
      tx_data_q   <= tx_data_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      wr_pm_q     <= wr_pm_d;
      wr_dm_q     <= wr_dm_d;
      rd_dm_q     <= rd_dm_d;
      tx_start_q  <= tx_start_d;
      reset_bip_q <= reset_bip_d;
    end
  end

  assign tx_data           = tx_data_q;
  assign tx_start          = tx_start_q;
  assign reset_bip         = reset_bip_q;
  assign WrPM              = wr_pm_q;
  assign WrDM              = wr_dm_q;
  assign RdDM              = rd_dm_q;
  assign dataFromInterface = data_q;
  assign addrFromInterface = addr_q;

endmodule

// File: doc/debug_loader.md
DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 Parameter DATA_LENGTH, default 16: CPU data/instruction word width.
REQ-002 Parameter ADDR_LENGTH, default 11: program/data memory address width.
REQ-003 Parameter DUMP_WORDS, default 16: number of data-memory words returned by the dump command.
REQ-004 clk  in  1  single system clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rx_data  in  8  received byte from the serial receiver.
REQ-007 rx_done  in  1  one-cycle pulse, rx_data valid.
REQ-008 tx_busy  in  1  serial transmitter busy.
REQ-009 tx_done  in  1  one-cycle pulse, byte transmission finished.
REQ-010 tx_data  out  8  byte to transmit.
REQ-011 tx_start  out  1  one-cycle pulse, start transmitting tx_data.
REQ-012 reset_bip  out  1  CPU reset, active-high.
REQ-013 WrPM  out  1  program memory write strobe.
REQ-014 WrDM / RdDM  out  1 each  data memory write / read strobes.
REQ-015 dataFromInterface  out  DATA_LENGTH  write data to program/data memory.
REQ-016 addrFromInterface  out  ADDR_LENGTH  address to program/data memory.
REQ-017 outAcc, outPC, data_from_dm  in  DATA_LENGTH each  CPU accumulator, PC, data memory read data.

Function
REQ-018 The block SHALL decode a command byte in IDLE: 0x01 LOAD_PM, 0x02 RUN, 0x03 DUMP, 0x04 WRITE_DM; any other byte SHALL be discarded and the FSM stays in IDLE.
REQ-019 Multi-byte fields SHALL be received high byte first; each 16-bit word is assembled from two rx_done bytes.
REQ-020 LOAD_PM: receive count N (16 bit), then N words; each completed word SHALL produce a one-cycle WrPM with addrFromInterface = 0,1,2,... (modulo 2^ADDR_LENGTH) and dataFromInterface = word.
REQ-021 LOAD_PM with N = 0 SHALL return to IDLE with no WrPM pulse.
REQ-022 WRITE_DM: receive address (16 bit, low ADDR_LENGTH bits used) and data word, then one-cycle WrDM with that address/data, return to IDLE.
REQ-023 RUN: receive cycle count C; reset_bip SHALL be 0 for exactly C consecutive cycles starting the cycle after the last count byte, then return to 1; C = 0 SHALL not release reset_bip.
REQ-024 reset_bip SHALL be 1 in every state except RUNNING; WrPM, WrDM, RdDM SHALL be 0 in RUNNING.
REQ-025 DUMP: transmit outAcc, outPC, then DM[0..DUMP_WORDS-1], each word high byte first, 2*(DUMP_WORDS+2) bytes total.
REQ-026 Data memory read: RdDM and addrFromInterface asserted one cycle; data_from_dm SHALL be captured on the following cycle.
REQ-027 tx_start SHALL pulse only when tx_busy = 0; the next byte SHALL not start before tx_done for the previous one.
REQ-028 rx_done pulses arriving in RUNNING, DUMP or write cycles SHALL be ignored.
REQ-029 FSM states: IDLE, LD_CNT_H, LD_CNT_L, LD_HI, LD_LO, LD_WR, WD_AH, WD_AL, WD_DH, WD_DL, WD_WR, RUN_H, RUN_L, RUNNING, DUMP_RD, DUMP_CAP, TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT.
REQ-030 Strobes WrPM, WrDM, RdDM, tx_start SHALL be registered and never high for more than one consecutive cycle.

Reset
REQ-031 On reset: FSM = IDLE, reset_bip = 1, WrPM = WrDM = RdDM = tx_start = 0, tx_data = 0, dataFromInterface = 0, addrFromInterface = 0, all counters 0.
REQ-032 Reset mid-load, mid-run or mid-dump SHALL abort immediately; partially received words are discarded.

Structure
REQ-033 Command opcodes and state encodings SHALL reside in a shared package/include (debug_defs).
REQ-034 One sub-module is natural: word_assembler (two-byte to 16-bit collector with valid pulse).

Verification
REQ-035 LOAD_PM bytes 01 00 02 12 34 56 78 -> WrPM at addr 0 data 0x1234, then addr 1 data 0x5678, two pulses total.
REQ-036 RUN bytes 02 00 05 -> reset_bip low exactly 5 cycles, then high; RUN 02 00 00 -> reset_bip never low.
REQ-037 DUMP with outAcc=0xBEEF, outPC=0x0003, DM[0]=0x00AA -> first bytes BE EF 00 03 00 AA, 36 bytes total, one per tx_done.
REQ-038 WRITE_DM 04 00 07 CA FE -> single WrDM, address 7, data 0xCAFE.
REQ-039 Reset after 01 00 03 12 -> IDLE, no WrPM; following 0x55 ignored; next 01 00 01 AB CD writes addr 0.
